// File: rtl/axiuart_txarb.sv
// Two-source UART transmit arbiter: command bytes (bit7=1) and console bytes (bit7=0)
// share one transmitter through a single-byte holding register with bounded bursts.
module axiuart_txarb #(
    parameter int LGMAXBURST                  = 2,
    parameter bit CMD_PORT_OFF_UNTIL_ACCESSED = 1'b1
) (
    input  logic       S_AXI_ACLK,
    input  logic       S_AXI_ARESETN,
    input  logic       i_rx_stb,
    input  logic [7:0] i_rx_data,
    input  logic       i_cmd_stb,
    input  logic [6:0] i_cmd_data,
    output logic       o_cmd_busy,
    input  logic       i_console_stb,
    input  logic [6:0] i_console_data,
    output logic       o_console_busy,
    output logic       o_tx_stb,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    output logic       o_cmd_active,
    output logic [1:0] o_owner,
    output logic [7:0] o_drop_count
);

    localparam int CW = LGMAXBURST + 1;
    localparam logic [CW-1:0] MAXBURST = CW'(2 ** LGMAXBURST);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CMD  = 2'b01,
        OWN_CON  = 2'b10
    } owner_t;

    owner_t          owner, owner_d, grantee;
    logic [CW-1:0]   cnt, cnt_d;
    logic            full, full_d;
    logic [7:0]      data, data_d;
    logic            cmd_active;
    logic [7:0]      drop_count;
    logic            cmd_req, con_req;
    logic            grant_cmd, grant_con;
    logic            unused_rx;

    function automatic logic [CW-1:0] sat_inc_cnt(input logic [CW-1:0] v);
        return (v >= MAXBURST) ? MAXBURST : v + CW'(1);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only the MSB of a received byte matters: it marks host command traffic.
    assign unused_rx = ^i_rx_data[6:0];

    assign cmd_req = !full && i_cmd_stb && cmd_active;
    assign con_req = !full && i_console_stb;

    always_comb begin
        grant_cmd = 1'b0;
        grant_con = 1'b0;
        if (cmd_req && con_req) begin
            case (owner)
                OWN_CMD: begin
                    if (cnt < MAXBURST) grant_cmd = 1'b1;
                    else                grant_con = 1'b1;
                end
                OWN_CON: begin
                    if (cnt < MAXBURST) grant_con = 1'b1;
                    else                grant_cmd = 1'b1;
                end
                default: grant_cmd = 1'b1;
            endcase
        end else begin
            grant_cmd = cmd_req;
            grant_con = con_req;
        end
    end

    always_comb begin
        full_d  = full;
        data_d  = data;
        owner_d = owner;
        cnt_d   = cnt;
        grantee = grant_cmd ? OWN_CMD : OWN_CON;
        if (full) begin
            if (!i_tx_busy) full_d = 1'b0;
        end else if (grant_cmd || grant_con) begin
            full_d = 1'b1;
            data_d = grant_cmd ? {1'b1, i_cmd_data} : {1'b0, i_console_data};
            if (owner == grantee) begin
                cnt_d = sat_inc_cnt(cnt);
            end else begin
                owner_d = grantee;
                cnt_d   = CW'(1);
            end
        end else begin
            // Idle line ends any burst so the next contention starts fresh.
            owner_d = OWN_NONE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            full  <= 1'b0;
            data  <= 8'h00;
            owner <= OWN_NONE;
            cnt   <= '0;
        end else begin
            full  <= full_d;
            data  <= data_d;
            owner <= owner_d;
            cnt   <= cnt_d;
        end
    end

    // With the parameter clear, the flag resets to 1 and can never fall.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            cmd_active <= !CMD_PORT_OFF_UNTIL_ACCESSED;
        end else if (i_rx_stb && i_rx_data[7]) begin
            cmd_active <= 1'b1;
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            drop_count <= 8'h00;
        end else if (!cmd_active && i_cmd_stb) begin
            drop_count <= sat_inc8(drop_count);
        end
    end

    assign o_cmd_busy     = cmd_active && (full || !grant_cmd);
    assign o_console_busy = full || !grant_con;
    assign o_tx_stb       = full;
    assign o_tx_data      = data;
    assign o_cmd_active   = cmd_active;
    assign o_owner        = owner;
    assign o_drop_count   = drop_count;

endmodule

// File: tb/tb_axiuart_txarb.sv
// Bench for axiuart_txarb: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the arbitration rules.
module tb_axiuart_txarb;

    localparam int LGMAXBURST = 2;
    localparam int MAXB       = 1 << LGMAXBURST;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_stb = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       cmd_stb = 1'b0;
    logic [6:0] cmd_data = 7'h00;
    logic       cmd_busy;
    logic       con_stb = 1'b0;
    logic [6:0] con_data = 7'h00;
    logic       con_busy;
    logic       tx_stb;
    logic [7:0] tx_data;
    logic       tx_busy = 1'b0;
    logic       cmd_active;
    logic [1:0] owner;
    logic [7:0] drop_count;

    axiuart_txarb #(
        .LGMAXBURST(LGMAXBURST),
        .CMD_PORT_OFF_UNTIL_ACCESSED(1'b1)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .i_rx_stb(rx_stb),
        .i_rx_data(rx_data),
        .i_cmd_stb(cmd_stb),
        .i_cmd_data(cmd_data),
        .o_cmd_busy(cmd_busy),
        .i_console_stb(con_stb),
        .i_console_data(con_data),
        .o_console_busy(con_busy),
        .o_tx_stb(tx_stb),
        .o_tx_data(tx_data),
        .i_tx_busy(tx_busy),
        .o_cmd_active(cmd_active),
        .o_owner(owner),
        .o_drop_count(drop_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model: owner 0=none, 1=cmd, 2=console; burst = bytes in current run.
    bit m_active, m_full;
    int m_data, m_owner, m_burst, m_drop;
    bit exp_cmd_busy, exp_con_busy;
    logic obs_cmd_busy, obs_con_busy;
    int tx_high;
    int txq[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_full   = 1'b0;
        m_data   = 0;
        m_owner  = 0;
        m_burst  = 0;
        m_drop   = 0;
    endtask

    task automatic check_regs(input string pfx);
        check({pfx, "_tx_stb"}, 32'(tx_stb), 32'(m_full));
        check({pfx, "_tx_data"}, 32'(tx_data), 32'(m_data));
        check({pfx, "_owner"}, 32'(owner), 32'(m_owner));
        check({pfx, "_drop"}, 32'(drop_count), 32'(m_drop));
        check({pfx, "_active"}, 32'(cmd_active), 32'(m_active));
    endtask

    task automatic cycle(input logic rs, input logic [7:0] rd, input logic cs, input logic [6:0] cd,
                         input logic qs, input logic [6:0] qd, input logic tb);
        int win, n_owner, n_burst, n_data, n_drop;
        bit n_full, n_active, creq, qreq;
        @(negedge clk);
        rx_stb = rs; rx_data = rd; cmd_stb = cs; cmd_data = cd;
        con_stb = qs; con_data = qd; tx_busy = tb;
        #1;
        creq = !m_full && cs && m_active;
        qreq = !m_full && qs;
        win = 0;
        if (creq && qreq) win = (m_owner == 0) ? 1 : ((m_burst < MAXB) ? m_owner : 3 - m_owner);
        else if (creq) win = 1;
        else if (qreq) win = 2;
        exp_cmd_busy = m_active && (m_full || win != 1);
        exp_con_busy = m_full || win != 2;
        obs_cmd_busy = cmd_busy;
        obs_con_busy = con_busy;
        check("cmd_busy", 32'(cmd_busy), 32'(exp_cmd_busy));
        check("con_busy", 32'(con_busy), 32'(exp_con_busy));
        check_regs("cyc");
        if (tx_stb === 1'b1) tx_high++;
        if (tx_stb === 1'b1 && !tb) txq.push_back(int'(tx_data));
        n_active = m_active || (rs && rd[7]);
        n_drop   = (!m_active && cs) ? ((m_drop < 255) ? m_drop + 1 : 255) : m_drop;
        n_full = m_full; n_data = m_data; n_owner = m_owner; n_burst = m_burst;
        if (m_full) begin
            if (!tb) n_full = 1'b0;
        end else if (win != 0) begin
            n_full = 1'b1;
            n_data = (win == 1) ? 128 + int'(cd) : int'(qd);
            if (win == m_owner) n_burst = (m_burst < MAXB) ? m_burst + 1 : MAXB;
            else begin
                n_owner = win;
                n_burst = 1;
            end
        end else begin
            n_owner = 0;
            n_burst = 0;
        end
        @(posedge clk);
        m_active = n_active; m_drop = n_drop; m_full = n_full;
        m_data = n_data; m_owner = n_owner; m_burst = n_burst;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
    endtask

    // Sources hold each byte until accepted, then advance to the next value.
    task automatic stream(input int ncyc, input bit cen, input bit qen, input int cbase, input int qbase);
        int ci, qi;
        ci = cbase;
        qi = qbase;
        for (int k = 0; k < ncyc; k++) begin
            cycle(1'b0, 8'h00, cen, 7'(ci), qen, 7'(qi), 1'b0);
            if (cen && !exp_cmd_busy) ci++;
            if (qen && !exp_con_busy) qi++;
        end
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_tx_stb", 32'(tx_stb), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_active", 32'(cmd_active), 32'd0);
        rx_stb = 1'b0; cmd_stb = 1'b0; con_stb = 1'b0; tx_busy = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        tx_high = 0;
        repeat (2) @(negedge clk);
        check("init_tx_stb", 32'(tx_stb), 32'd0);
        check("init_cmd_busy", 32'(cmd_busy), 32'd0);
        check_regs("init");
        rst_n = 1'b1;

        // Commands before host access are swallowed and counted.
        tx_high = 0;
        for (int k = 0; k < 3; k++) cycle(1'b0, 8'h00, 1'b1, 7'h41, 1'b0, 7'h00, 1'b0);
        #1;
        check("drop_3", 32'(drop_count), 32'd3);
        for (int k = 0; k < 255; k++) cycle(1'b0, 8'h00, 1'b1, 7'h41, 1'b0, 7'h00, 1'b0);
        #1;
        check("drop_sat", 32'(drop_count), 32'd255);
        check("drop_no_tx", 32'(tx_high), 32'd0);

        // Host command byte enables the command port.
        cycle(1'b1, 8'h80, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
        #1;
        check("active_set", 32'(cmd_active), 32'd1);
        cycle(1'b0, 8'h00, 1'b1, 7'h55, 1'b0, 7'h00, 1'b0);
        #1;
        check("cmd_tx_stb", 32'(tx_stb), 32'd1);
        check("cmd_tx_data", 32'(tx_data), 32'hD5);
        idle(1);
        #1;
        check("cmd_tx_done", 32'(tx_stb), 32'd0);

        // Console byte held by a busy transmitter.
        tx_high = 0;
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 7'h30, 1'b1);
        #1;
        check("con_busy_full", 32'(con_busy), 32'd1);
        for (int k = 0; k < 5; k++) cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
        idle(1);
        check("con_hold_cycles", 32'(tx_high), 32'd6);

        // Simultaneous requests from idle: command wins.
        idle(1);
        cycle(1'b0, 8'h00, 1'b1, 7'h01, 1'b1, 7'h02, 1'b0);
        check("both_cmd_busy", 32'(obs_cmd_busy), 32'd0);
        check("both_con_busy", 32'(obs_con_busy), 32'd1);
        #1;
        check("both_owner", 32'(owner), 32'd1);
        check("both_data", 32'(tx_data), 32'h81);
        idle(2);

        // Burst interleave: 4 cmd, 4 console, 4 cmd.
        txq.delete();
        stream(26, 1'b1, 1'b1, 0, 0);
        idle(2);
        check("burst_count", 32'(txq.size() >= 12), 32'd1);
        if (txq.size() >= 12) begin
            for (int i = 0; i < 12; i++) begin
                int e;
                e = (i < 4) ? 128 + i : ((i < 8) ? i - 4 : 128 + i - 4);
                check($sformatf("burst_%0d", i), 32'(txq[i]), 32'(e));
            end
        end

        // Reset with a byte stuck in the holding register.
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 7'h33, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b0, 7'h00, 1'b1);
        async_reset();
        cycle(1'b1, 8'h80, 1'b0, 7'h00, 1'b0, 7'h00, 1'b0);
        txq.delete();
        cycle(1'b0, 8'h00, 1'b0, 7'h00, 1'b1, 7'h20, 1'b0);
        #1;
        check("post_rst_owner", 32'(owner), 32'd2);
        check("post_rst_data", 32'(tx_data), 32'h20);
        stream(12, 1'b1, 1'b1, 0, 8'h21);
        idle(2);
        check("post_rst_count", 32'(txq.size() >= 5), 32'd1);
        if (txq.size() >= 5) begin
            for (int i = 0; i < 5; i++) begin
                int e;
                e = (i < 4) ? 32 + i : 128;
                check($sformatf("post_rst_%0d", i), 32'(txq[i]), 32'(e));
            end
        end

        // Random traffic against the model.
        for (int k = 0; k < 400; k++) begin
            cycle(($urandom % 16) == 0, 8'($urandom), ($urandom % 2) == 0, 7'($urandom),
                  ($urandom % 2) == 0, 7'($urandom), ($urandom % 10) < 3);
        end
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axiuart_txarb.md
AXIUART_TXARB -- requirements
Module: axiuart_txarb

Interface
REQ-001 SHALL have parameter LGMAXBURST, default 2, meaning log2 of the maximum consecutive bytes one source may send while the other source waits (MAXBURST = 2^LGMAXBURST).
REQ-002 SHALL have parameter CMD_PORT_OFF_UNTIL_ACCESSED, default 1'b1, meaning the command source is ignored until the first host command byte arrives.
REQ-003 SHALL have one clock, S_AXI_ACLK, with all state updated on its rising edge.
REQ-004 SHALL have reset S_AXI_ARESETN, which is asynchronous and active-low.
REQ-005 SHALL have ports: S_AXI_ACLK in 1 clock; S_AXI_ARESETN in 1 async active-low reset.
REQ-006 SHALL have ports: i_rx_stb in 1 received-byte strobe; i_rx_data in 8 received byte.
REQ-007 SHALL have ports: i_cmd_stb in 1 command byte valid; i_cmd_data in 7 command byte payload; o_cmd_busy out 1 command stall.
REQ-008 SHALL have ports: i_console_stb in 1 console byte valid; i_console_data in 7 console payload; o_console_busy out 1 console stall.
REQ-009 SHALL have ports: o_tx_stb out 1 TX byte valid; o_tx_data out 8 TX byte; i_tx_busy in 1 transmitter busy.
REQ-010 SHALL have ports: o_cmd_active out 1 command port enabled; o_owner out 2 current owner (00 none, 01 cmd, 10 console); o_drop_count out 8 dropped command bytes.

Function
REQ-011 A source byte SHALL be transferred in any cycle where its stb is high and its busy is low.
REQ-012 If CMD_PORT_OFF_UNTIL_ACCESSED=1, cmd_active SHALL set the cycle after i_rx_stb && i_rx_data[7], and clear only on reset; otherwise it SHALL be constant 1.
REQ-013 While cmd_active=0, o_cmd_busy SHALL be 0 and accepted command bytes SHALL be discarded.
REQ-014 While cmd_active=0, o_drop_count SHALL increment for each discarded byte, saturating at 255.
REQ-015 The arbiter SHALL keep a one-byte holding register (full, data); o_tx_stb = full and o_tx_data = data.
REQ-016 full SHALL clear in the cycle after full && !i_tx_busy; no load SHALL occur in a cycle where full=1, so there is at most one byte per two clocks.
REQ-017 When full=0, cmd_req = i_cmd_stb && cmd_active and con_req = i_console_stb.
REQ-018 If only one request is present, that source SHALL be granted.
REQ-019 If both requests are present: grant the owner if cnt < MAXBURST; else grant the non-owner; if owner=none, grant cmd.
REQ-020 A grant SHALL load full=1, with data {1'b1,i_cmd_data} for cmd or {1'b0,i_console_data} for console.
REQ-021 On a grant to the current owner, cnt SHALL increment, saturating at MAXBURST; otherwise owner SHALL become the grantee and cnt SHALL become 1.
REQ-022 If full=0 and there is no request, owner SHALL become none and cnt SHALL become 0.
REQ-023 o_cmd_busy SHALL equal cmd_active && (full || !grant_cmd), and o_console_busy SHALL equal full || !grant_con; both are combinational, with the same-cycle grant.
REQ-024 cnt SHALL be LGMAXBURST+1 bits wide.
REQ-025 i_tx_busy SHALL be ignored while full=0.

Reset
REQ-026 On S_AXI_ARESETN low, asynchronously: full=0, o_tx_stb=0, o_tx_data=0, owner=none, cnt=0, o_drop_count=0, and cmd_active=0 (or 1 when the parameter is 0).
REQ-027 A byte in the holding register at reset SHALL be lost; after deassertion, the first grant SHALL follow REQ-017 to REQ-022 with no stale state.

Verification
REQ-028 Reset, then 3 command bytes 0x41 with cmd_active=0 -> o_tx_stb never asserted; o_drop_count=3; o_cmd_busy=0 throughout.
REQ-029 i_rx_stb with i_rx_data=0x80, then command 0x55 and i_tx_busy=0 -> o_cmd_active=1 next cycle; o_tx_data=0xD5, o_tx_stb for one cycle.
REQ-030 Console 0x30 only, i_tx_busy held high 5 cycles -> o_tx_stb high 6 cycles with o_tx_data=0x30; o_console_busy high while full.
REQ-031 LGMAXBURST=2, cmd active, both sources streaming, i_tx_busy=0 -> TX order is 4 cmd bytes (bit7=1), 4 console bytes, 4 cmd bytes; no byte lost or duplicated.
REQ-032 Both sources request simultaneously from owner=none -> cmd granted first; o_owner=01; console stalled.
REQ-033 Assert reset while full=1 and i_tx_busy=1 -> o_tx_stb=0 immediately; after release, the next console byte is granted with cnt=1.
